sobel_binarizer_stream: RTL and testbench
=========================================

# sobel_binarizer_stream

Parametrised successor to the single-threshold Sobel binariser. Turns a stream of DATA_W-bit Sobel magnitudes into 1-bit black/white pixels using a fixed or hysteresis threshold, tracks column/row position to flag line and frame ends, and buffers results in a small FIFO with a valid/ready handshake toward the VGA image path. It sits between `sobel` and the VGA pixel consumer in `main`.

## Interface
- DATA_W, 8: width of the Sobel magnitude.
- FIFO_DEPTH, 16: output FIFO entries; power of two, at least 2.
- IMG_W, 512: pixels per line.
- IMG_H, 512: lines per frame.
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- data  in  DATA_W  Sobel magnitude.
- data_valid  in  1  qualifies data; always accepted, no back-pressure upstream.
- mode  in  1  0 = fixed threshold, 1 = hysteresis.
- thr_hi  in  DATA_W  upper threshold; sampled with each valid pixel.
- thr_lo  in  DATA_W  lower threshold (hysteresis only).
- bit  out  1  FIFO head pixel (1 = white, 0 = edge/black).
- bit_valid  out  1  FIFO not empty.
- bit_ready  in  1  consumer pops head when bit_valid && bit_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a pixel is dropped.
- line_done  out  1  one-cycle pulse, last pixel of a line classified.
- frame_done  out  1  one-cycle pulse, last pixel of a frame classified.

## Operation
- Classification (combinational on input, registered into stage):
  - mode 0: pixel = (data > thr_hi) ? 0 : 1 (thr_hi = 100 reproduces the legacy behaviour).
  - mode 1: state `hyst`; data > thr_hi -> 0; else data < thr_lo -> 1; else hold `hyst`. If thr_lo > thr_hi and both compares are true, the > thr_hi rule wins (0). `hyst` is forced to 1 before the comparison for column 0 of every line.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) advance per accepted pixel; col wraps to 0 and row increments; row wraps to 0 after IMG_H-1.
- line_done pulses with col == IMG_W-1; frame_done additionally requires row == IMG_H-1 (both pulse together).
- Stage register writes the FIFO one cycle after acceptance.
- FIFO write when full without a same-cycle pop: pixel dropped, overflow set; cleared only by reset. Counters still advance.
- Full with simultaneous pop: write and pop both happen, level unchanged.
- Pop when empty: ignored; level never underflows.
- mode changes take effect on the next accepted pixel; the `hyst` value is retained.

## Timing
- Reset values: bit = 0, bit_valid = 0, fifo_level = 0, overflow = 0, line_done = 0, frame_done = 0; col = row = 0, `hyst` = 1, stage empty.
- Latency: data_valid at edge N -> stage at N -> FIFO write at N+1 -> bit_valid high after edge N+1 (2 edges) when FIFO empty.
- line_done and frame_done are asserted for the cycle after edge N (aligned with the stage register).
- Back-to-back valid pixels every cycle are sustained.
- bit is show-ahead: the head is valid combinationally from the FIFO output while bit_valid = 1.
- Reset mid-frame: all state cleared asynchronously; in-flight and buffered pixels are discarded.

## Structure
- Package `sobel_bw_pkg`: mode constants (MODE_FIXED = 0, MODE_HYST = 1), default threshold 100, default IMG_W and IMG_H.
- Sub-module `bit_fifo`: parametrised depth, 1-bit synchronous FIFO with show-ahead read, level output, and full/empty flags.
- Classifier, hysteresis state, counters and stage register live in the top module.

## Test plan
- mode 0, thr_hi = 100; feed 99, 100, 101, 255 with bit_ready = 1 -> bits 1, 1, 0, 0; first bit_valid 2 edges after first input.
- mode 1, thr_hi = 100, thr_lo = 50; feed 120, 80, 60, 40, 80 -> 0, 0, 0, 1, 1.
- IMG_W = 4, IMG_H = 2; feed 8 pixels -> line_done after pixels 4 and 8; frame_done only after pixel 8; counters back to 0.
- FIFO_DEPTH = 4, bit_ready = 0; feed 6 pixels -> fifo_level = 4, overflow = 1. Then pop 4 -> the first 4 pixels are returned in order.
- With the FIFO full, pop and feed in the same cycle -> level stays 4, overflow unchanged, the new pixel appears last.
- Assert reset mid-line with 3 pixels buffered -> bit_valid = 0 and fifo_level = 0 immediately. The next line starts at col 0 with `hyst` = 1.

Source files
------------

// File: rtl/sobel_bw_pkg.sv
// Shared constants and types for the Sobel black/white binariser stream.
// Mode encoding, default threshold/image size and the stage register layout.
package sobel_bw_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_HYST  = 1'b1
    } mode_e;

    localparam int unsigned DEF_THR   = 100;
    localparam int unsigned DEF_IMG_W = 512;
    localparam int unsigned DEF_IMG_H = 512;

    // One classified pixel plus the position flags that travel with it.
    typedef struct packed {
        logic valid;
        logic pix;
        logic line_end;
        logic frame_end;
    } stage_t;

endpackage

// File: rtl/bit_fifo.sv
// 1-bit synchronous FIFO with show-ahead read, occupancy and full/empty flags.
// A write into a full FIFO is accepted only when a pop happens on the same edge.
module bit_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       wr_en_i,
    input  logic                       wr_data_i,
    input  logic                       rd_en_i,
    output logic                       rd_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == {LW{1'b0}});
    assign do_rd_s   = rd_en_i & ~empty_o;
    assign do_wr_s   = wr_en_i & (~full_o | do_rd_s);
    assign rd_data_o = ~empty_o & mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr_s) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/sobel_binarizer_stream.sv
// Sobel magnitude to black/white pixel stream: fixed or hysteresis threshold,
// line/frame position tracking, and a small output FIFO with valid/ready.
module sobel_binarizer_stream
    import sobel_bw_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          data_valid_i,
    input  logic                          mode_i,
    input  logic [DATA_W-1:0]             thr_hi_i,
    input  logic [DATA_W-1:0]             thr_lo_i,
    output logic                          bit_o,
    output logic                          bit_valid_o,
    input  logic                          bit_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          line_done_o,
    output logic                          frame_done_o
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             hyst_q, hyst_d;
    stage_t           stage_q, stage_d;
    logic             overflow_q, overflow_d;

    logic             hyst_eff_s;
    logic             pix_s;
    logic             last_col_s;
    logic             last_row_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_pop_s;

    assign last_col_s = (col_q == COL_W'(IMG_W - 1));
    assign last_row_s = (row_q == ROW_W'(IMG_H - 1));
    assign fifo_pop_s = bit_ready_i & ~fifo_empty_s;

    // Pixel classification; the hysteresis memory restarts white on each line.
    always_comb begin
        hyst_eff_s = hyst_q;
        pix_s      = 1'b1;
        if (col_q == {COL_W{1'b0}}) begin
            hyst_eff_s = 1'b1;
        end else begin
            hyst_eff_s = hyst_q;
        end
        if (mode_i == MODE_HYST) begin
            if (data_i > thr_hi_i) begin
                pix_s = 1'b0;
            end else if (data_i < thr_lo_i) begin
                pix_s = 1'b1;
            end else begin
                pix_s = hyst_eff_s;
            end
        end else begin
            if (data_i > thr_hi_i) begin
                pix_s = 1'b0;
            end else begin
                pix_s = 1'b1;
            end
        end
    end

    // Position counters, hysteresis state, stage register and sticky overflow.
    always_comb begin
        col_d              = col_q;
        row_d              = row_q;
        hyst_d             = hyst_q;
        stage_d.valid      = 1'b0;
        stage_d.pix        = 1'b0;
        stage_d.line_end   = 1'b0;
        stage_d.frame_end  = 1'b0;
        overflow_d         = overflow_q | (stage_q.valid & fifo_full_s & ~fifo_pop_s);
        if (data_valid_i) begin
            stage_d.valid     = 1'b1;
            stage_d.pix       = pix_s;
            stage_d.line_end  = last_col_s;
            stage_d.frame_end = last_col_s & last_row_s;
            if (mode_i == MODE_HYST) begin
                hyst_d = pix_s;
            end else begin
                hyst_d = hyst_q;
            end
            if (last_col_s) begin
                col_d = {COL_W{1'b0}};
                if (last_row_s) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1'b1);
                end
            end else begin
                col_d = col_q + COL_W'(1'b1);
                row_d = row_q;
            end
        end else begin
            col_d  = col_q;
            row_d  = row_q;
            hyst_d = hyst_q;
        end
    end

    // Control and stage registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            col_q      <= {COL_W{1'b0}};
            row_q      <= {ROW_W{1'b0}};
            hyst_q     <= 1'b1;
            stage_q    <= 4'b0000;
            overflow_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            hyst_q     <= hyst_d;
            stage_q    <= stage_d;
            overflow_q <= overflow_d;
        end
    end

    bit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_en_i   (stage_q.valid),
        .wr_data_i (stage_q.pix),
        .rd_en_i   (fifo_pop_s),
        .rd_data_o (bit_o),
        .level_o   (fifo_level_o),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    assign bit_valid_o  = ~fifo_empty_s;
    assign overflow_o   = overflow_q;
    assign line_done_o  = stage_q.line_end;
    assign frame_done_o = stage_q.frame_end;

endmodule

// File: tb/tb_sobel_binarizer_stream.sv
// Directed bench for sobel_binarizer_stream with a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_sobel_binarizer_stream;
    import sobel_bw_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data = 8'd0;
    logic          data_valid = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] thr_hi = 8'd100;
    logic [DW-1:0] thr_lo = 8'd50;
    logic          bit_ready = 1'b0;
    logic          pix_bit;
    logic          bit_valid;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          line_done;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    sobel_binarizer_stream #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .IMG_W(W), .IMG_H(H)
    ) dut (
        .clk_i(clk), .reset_i(reset), .data_i(data), .data_valid_i(data_valid),
        .mode_i(mode), .thr_hi_i(thr_hi), .thr_lo_i(thr_lo),
        .bit_o(pix_bit), .bit_valid_o(bit_valid), .bit_ready_i(bit_ready),
        .fifo_level_o(fifo_level), .overflow_o(overflow),
        .line_done_o(line_done), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents and registered flags.
    logic m_q[$];
    int   m_col = 0;
    int   m_row = 0;
    logic m_hyst = 1'b1;
    logic m_sv = 1'b0, m_sp = 1'b0, m_ld = 1'b0, m_fd = 1'b0, m_ovf = 1'b0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_q.delete();
            m_col = 0; m_row = 0; m_hyst = 1'b1;
            m_sv = 1'b0; m_sp = 1'b0; m_ld = 1'b0; m_fd = 1'b0; m_ovf = 1'b0;
        end else begin
            if (bit_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (m_sv) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_sp);
                else m_ovf = 1'b1;
            end
            m_sv = data_valid; m_ld = 1'b0; m_fd = 1'b0;
            if (data_valid) begin
                if (mode == MODE_FIXED) begin
                    m_sp = (data > thr_hi) ? 1'b0 : 1'b1;
                end else begin
                    if (m_col == 0) m_hyst = 1'b1;
                    if (data > thr_hi)      m_sp = 1'b0;
                    else if (data < thr_lo) m_sp = 1'b1;
                    else                    m_sp = m_hyst;
                    m_hyst = m_sp;
                end
                m_ld = (m_col == W - 1);
                m_fd = m_ld && (m_row == H - 1);
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    m_row = (m_row == H - 1) ? 0 : m_row + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("bit_valid", bit_valid, m_q.size() != 0);
            check("fifo_level", fifo_level, m_q.size());
            check("bit", pix_bit, (m_q.size() != 0) ? m_q[0] : 1'b0);
            check("overflow", overflow, m_ovf);
            check("line_done", line_done, m_ld);
            check("frame_done", frame_done, m_fd);
        end
    end

    // Record every bit the consumer pops.
    logic got_q[$];
    initial forever begin
        @(negedge clk);
        if (!reset && bit_valid && bit_ready) got_q.push_back(pix_bit);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [DW-1:0] d);
        data = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Compares popped bits against n literal bits, listed MSB first in e.
    task automatic expect_bits(input string name, input logic [7:0] e, input int n);
        check({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check(name, (i < got_q.size()) ? got_q[i] : 1'bx, e[n-1-i]);
        end
    endtask

    initial begin
        logic [11:0] ld_exp;
        logic [11:0] fd_exp;
        logic [DW-1:0] t4_pix [6];

        do_reset();
        check("rst_bit", pix_bit, 1'b0);
        check("rst_bit_valid", bit_valid, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_line_done", line_done, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);

        // Fixed threshold and two-edge latency.
        mode = MODE_FIXED; thr_hi = 8'(DEF_THR); bit_ready = 1'b1;
        got_q.delete();
        feed(8'd99);
        check("t1_valid_after_1", bit_valid, 1'b0);
        feed(8'd100);
        check("t1_valid_after_2", bit_valid, 1'b1);
        check("t1_first_bit", pix_bit, 1'b1);
        feed(8'd101);
        feed(8'd255);
        repeat (3) tick();
        expect_bits("t1_bits", 8'b0000_1100, 4);

        // Hysteresis; the fifth pixel starts a new line.
        do_reset();
        mode = MODE_HYST; thr_hi = 8'd100; thr_lo = 8'd50; bit_ready = 1'b1;
        got_q.delete();
        feed(8'd120); feed(8'd80); feed(8'd60); feed(8'd40); feed(8'd80);
        repeat (3) tick();
        expect_bits("t2_bits", 8'b0000_0011, 5);

        // Line and frame pulses over one and a half frames.
        do_reset();
        mode = MODE_FIXED; bit_ready = 1'b1;
        ld_exp = 12'b1000_1000_1000;
        fd_exp = 12'b0000_1000_0000;
        for (int i = 0; i < 12; i++) begin
            feed(8'(i * 20));
            check("t3_line_done", line_done, ld_exp[i]);
            check("t3_frame_done", frame_done, fd_exp[i]);
        end
        repeat (2) tick();

        // Overflow with consumer stalled, then in-order drain.
        do_reset();
        bit_ready = 1'b0;
        t4_pix = '{8'd200, 8'd10, 8'd200, 8'd200, 8'd10, 8'd10};
        foreach (t4_pix[i]) feed(t4_pix[i]);
        repeat (2) tick();
        check("t4_level_full", fifo_level, 4);
        check("t4_overflow", overflow, 1'b1);
        got_q.delete();
        bit_ready = 1'b1;
        repeat (4) tick();
        bit_ready = 1'b0;
        expect_bits("t4_bits", 8'b0000_0100, 4);
        check("t4_level_empty", fifo_level, 0);
        tick();

        // Full FIFO with a simultaneous write and pop.
        do_reset();
        bit_ready = 1'b0;
        feed(8'd200); feed(8'd10); feed(8'd10); feed(8'd10);
        tick();
        check("t5_level_full", fifo_level, 4);
        feed(8'd200);
        bit_ready = 1'b1;
        tick();
        bit_ready = 1'b0;
        check("t5_level_kept", fifo_level, 4);
        check("t5_overflow_kept", overflow, 1'b0);
        got_q.delete();
        bit_ready = 1'b1;
        repeat (5) tick();
        expect_bits("t5_bits", 8'b0000_1110, 4);

        // Asynchronous reset mid-line with three pixels buffered.
        do_reset();
        mode = MODE_HYST; bit_ready = 1'b0;
        feed(8'd120); feed(8'd80); feed(8'd80);
        tick();
        check("t6_level_before", fifo_level, 3);
        reset = 1'b1;
        #1;
        check("t6_bit_valid_rst", bit_valid, 1'b0);
        check("t6_level_rst", fifo_level, 0);
        tick();
        reset = 1'b0;
        tick();
        got_q.delete();
        bit_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            feed(8'd80);
            check("t6_line_done", line_done, (i == 3) ? 1'b1 : 1'b0);
        end
        repeat (3) tick();
        expect_bits("t6_bits", 8'b0000_1111, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
